// File: rtl/bt_txslot_sched.sv
// Master-side TX slot scheduler: arbitrates SCO > ACL > POLL at each master TX slot
// boundary, launches the packet into the bit processor and tracks it to completion.
module bt_txslot_sched #(
    parameter int         TX_TIMEOUT_US = 400,
    parameter logic [3:0] SCO_TYPE      = 4'h5,
    parameter logic [9:0] SCO_LEN       = 10'd10,
    parameter logic [3:0] POLL_TYPE     = 4'h1
) (
    input  logic        clk_6M,
    input  logic        rst,
    input  logic        p_1us,
    input  logic [27:0] CLK,
    input  logic        conns,
    input  logic        sco_slot,
    input  logic        acl_req,
    input  logic [3:0]  acl_pk_type,
    input  logic [9:0]  acl_len,
    input  logic [2:0]  acl_slots,
    input  logic        poll_req,
    input  logic        txbit_period,
    output logic        tx_packet_st_p,
    output logic        pk_encode,
    output logic [3:0]  regi_packet_type,
    output logic [9:0]  regi_payloadlen,
    output logic        acl_gnt,
    output logic        acl_done,
    output logic        poll_done,
    output logic        tx_err,
    output logic        sched_busy
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_TX} state_t;

    localparam logic [1:0] WIN_SCO  = 2'd0;
    localparam logic [1:0] WIN_ACL  = 2'd1;
    localparam logic [1:0] WIN_POLL = 2'd2;
    localparam logic [8:0] TIMEOUT  = 9'(TX_TIMEOUT_US);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_clk_prev;
    logic        r_bnd;
    logic [1:0]  r_skip_cnt;
    logic [1:0]  r_skip_ld;
    logic [1:0]  r_win;
    logic [8:0]  r_timer;
    logic        r_txbit_d;
    logic        r_txbit_seen;
    logic        r_acl_done;
    logic        r_poll_done;
    logic        r_tx_err;
    logic [3:0]  r_pk_type;
    logic [9:0]  r_len;

    logic        w_bnd_det;
    logic        w_any_req;
    logic        w_arb;
    logic        w_txbit_fall;
    logic        w_timeout;
    logic [1:0]  w_acl_skip;
    logic        w_unused;

    assign w_unused     = ^CLK[27:2];
    assign w_bnd_det    = (CLK[1:0] == 2'b00) && (r_clk_prev != 2'b00);
    assign w_any_req    = sco_slot | acl_req | poll_req;
    assign w_arb        = r_bnd && (r_skip_cnt == 2'd0) && w_any_req;
    assign w_txbit_fall = r_txbit_d & ~txbit_period;
    // Timeout only applies while the bit processor has not yet opened its window
    assign w_timeout    = !r_txbit_seen && (r_timer >= TIMEOUT);

    always_comb begin
        case (acl_slots)
            3'd3:    w_acl_skip = 2'd1;
            3'd5:    w_acl_skip = 2'd2;
            default: w_acl_skip = 2'd0;
        endcase
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!conns) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_arb) w_next = S_START;
                S_START: w_next = S_TX;
                S_TX:    if (w_txbit_fall || w_timeout) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_packet_st_p = (r_state == S_START);
        pk_encode      = (r_state == S_START) || (r_state == S_TX);
        acl_gnt        = (r_state == S_START) && (r_win == WIN_ACL);
        sched_busy     = (r_state != S_IDLE);
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_clk_prev <= 2'b00;
            r_bnd      <= 1'b0;
            r_txbit_d  <= 1'b0;
        end else begin
            r_clk_prev <= CLK[1:0];
            r_bnd      <= w_bnd_det;
            r_txbit_d  <= txbit_period;
        end
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_skip_cnt   <= 2'd0;
            r_skip_ld    <= 2'd0;
            r_win        <= WIN_SCO;
            r_timer      <= 9'd0;
            r_txbit_seen <= 1'b0;
            r_acl_done   <= 1'b0;
            r_poll_done  <= 1'b0;
            r_tx_err     <= 1'b0;
            r_pk_type    <= 4'h0;
            r_len        <= 10'd0;
        end else begin
            r_acl_done  <= 1'b0;
            r_poll_done <= 1'b0;
            r_tx_err    <= 1'b0;
            if (!conns) begin
                r_skip_cnt <= 2'd0;
                if (r_state != S_IDLE) r_tx_err <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_bnd && r_skip_cnt != 2'd0) begin
                            r_skip_cnt <= r_skip_cnt - 2'd1;
                        end else if (w_arb) begin
                            if (sco_slot) begin
                                r_win     <= WIN_SCO;
                                r_pk_type <= SCO_TYPE;
                                r_len     <= SCO_LEN;
                                r_skip_ld <= 2'd0;
                            end else if (acl_req) begin
                                r_win     <= WIN_ACL;
                                r_pk_type <= acl_pk_type;
                                r_len     <= acl_len;
                                r_skip_ld <= w_acl_skip;
                            end else begin
                                r_win     <= WIN_POLL;
                                r_pk_type <= POLL_TYPE;
                                r_len     <= 10'd0;
                                r_skip_ld <= 2'd0;
                            end
                        end
                    end
                    S_START: begin
                        r_skip_cnt   <= r_skip_ld;
                        r_timer      <= 9'd0;
                        r_txbit_seen <= 1'b0;
                    end
                    S_TX: begin
                        if (txbit_period) r_txbit_seen <= 1'b1;
                        if (p_1us && r_timer != 9'h1FF) r_timer <= r_timer + 9'd1;
                        if (w_txbit_fall) begin
                            r_acl_done  <= (r_win == WIN_ACL);
                            r_poll_done <= (r_win == WIN_POLL);
                        end else if (w_timeout) begin
                            r_tx_err   <= 1'b1;
                            r_skip_cnt <= 2'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign regi_packet_type = r_pk_type;
    assign regi_payloadlen  = r_len;
    assign acl_done         = r_acl_done;
    assign poll_done        = r_poll_done;
    assign tx_err           = r_tx_err;

endmodule

// File: tb/tb_bt_txslot_sched.sv
// Directed bench for bt_txslot_sched: poll, multi-slot ACL, priority, timeout, conns drop, reset.
module tb_bt_txslot_sched;

    logic        clk_6M = 1'b0;
    logic        rst;
    logic        p_1us = 1'b0;
    logic [27:0] CLK;
    logic        conns, sco_slot, acl_req, poll_req, txbit_period;
    logic [3:0]  acl_pk_type;
    logic [9:0]  acl_len;
    logic [2:0]  acl_slots;
    logic        tx_packet_st_p, pk_encode, acl_gnt, acl_done, poll_done, tx_err, sched_busy;
    logic [3:0]  regi_packet_type;
    logic [9:0]  regi_payloadlen;

    int n_vec = 0;
    int n_err = 0;
    int us_div = 0;

    bt_txslot_sched dut (
        .clk_6M(clk_6M), .rst(rst), .p_1us(p_1us), .CLK(CLK), .conns(conns),
        .sco_slot(sco_slot), .acl_req(acl_req), .acl_pk_type(acl_pk_type),
        .acl_len(acl_len), .acl_slots(acl_slots), .poll_req(poll_req),
        .txbit_period(txbit_period), .tx_packet_st_p(tx_packet_st_p),
        .pk_encode(pk_encode), .regi_packet_type(regi_packet_type),
        .regi_payloadlen(regi_payloadlen), .acl_gnt(acl_gnt), .acl_done(acl_done),
        .poll_done(poll_done), .tx_err(tx_err), .sched_busy(sched_busy)
    );

    initial forever #5 clk_6M = ~clk_6M;

    // 1 us strobe: one cycle in six, changed just after the edge so it is stable across the next edge
    initial forever begin
        @(posedge clk_6M);
        #2;
        us_div = (us_div == 5) ? 0 : us_div + 1;
        p_1us  = (us_div == 0);
    end

    task tick;
        @(posedge clk_6M);
        #1;
    endtask

    // After return the registered boundary pulse is high for the current cycle
    task boundary;
        CLK[1:0] = 2'b11;
        tick();
        CLK = {CLK[27:2] + 26'd1, 2'b00};
        tick();
    endtask

    task pulse_tx(input int n);
        txbit_period = 1'b1;
        repeat (n) tick();
        txbit_period = 1'b0;
        tick();
    endtask

    task test_reset;
        if ({tx_packet_st_p, pk_encode, acl_gnt, acl_done, poll_done, tx_err, sched_busy} !== 7'b0) begin
            $display("FAIL reset_ctl: got %b want 0000000",
                     {tx_packet_st_p, pk_encode, acl_gnt, acl_done, poll_done, tx_err, sched_busy});
            n_err++;
        end
        n_vec++;
        if (regi_packet_type !== 4'h0) begin
            $display("FAIL reset_type: got %h want 0", regi_packet_type); n_err++;
        end
        n_vec++;
        if (regi_payloadlen !== 10'd0) begin
            $display("FAIL reset_len: got %0d want 0", regi_payloadlen); n_err++;
        end
        n_vec++;
    endtask

    task test_poll;
        poll_req = 1'b1;
        boundary();
        tick();
        if ({tx_packet_st_p, pk_encode, acl_gnt} !== 3'b110) begin
            $display("FAIL poll_start: got %b want 110", {tx_packet_st_p, pk_encode, acl_gnt}); n_err++;
        end
        n_vec++;
        if ({regi_packet_type, regi_payloadlen} !== {4'h1, 10'd0}) begin
            $display("FAIL poll_fields: got %h/%0d want 1/0", regi_packet_type, regi_payloadlen); n_err++;
        end
        n_vec++;
        tick();
        if ({tx_packet_st_p, pk_encode, sched_busy} !== 3'b011) begin
            $display("FAIL poll_tx: got %b want 011", {tx_packet_st_p, pk_encode, sched_busy}); n_err++;
        end
        n_vec++;
        pulse_tx(126 * 6);
        if ({poll_done, acl_done, tx_err, pk_encode} !== 4'b1000) begin
            $display("FAIL poll_done: got %b want 1000", {poll_done, acl_done, tx_err, pk_encode}); n_err++;
        end
        n_vec++;
        poll_req = 1'b0;
        tick();
        if ({poll_done, sched_busy} !== 2'b00) begin
            $display("FAIL poll_idle: got %b want 00", {poll_done, sched_busy}); n_err++;
        end
        n_vec++;
    endtask

    task test_acl_multislot;
        acl_req = 1'b1; acl_pk_type = 4'hB; acl_len = 10'd339; acl_slots = 3'd5; poll_req = 1'b1;
        boundary();
        tick();
        if ({tx_packet_st_p, acl_gnt} !== 2'b11) begin
            $display("FAIL acl_gnt: got %b want 11", {tx_packet_st_p, acl_gnt}); n_err++;
        end
        n_vec++;
        if ({regi_packet_type, regi_payloadlen} !== {4'hB, 10'd339}) begin
            $display("FAIL acl_fields: got %h/%0d want b/339", regi_packet_type, regi_payloadlen); n_err++;
        end
        n_vec++;
        txbit_period = 1'b1;
        boundary();
        boundary();
        if ({sched_busy, tx_packet_st_p} !== 2'b10) begin
            $display("FAIL acl_bnd_in_tx: got %b want 10", {sched_busy, tx_packet_st_p}); n_err++;
        end
        n_vec++;
        pulse_tx(10);
        if ({acl_done, poll_done} !== 2'b10) begin
            $display("FAIL acl_done: got %b want 10", {acl_done, poll_done}); n_err++;
        end
        n_vec++;
        acl_req = 1'b0;
        boundary();
        tick();
        if ({tx_packet_st_p, sched_busy} !== 2'b00) begin
            $display("FAIL acl_skip1: got %b want 00", {tx_packet_st_p, sched_busy}); n_err++;
        end
        n_vec++;
        if ({regi_packet_type, regi_payloadlen} !== {4'hB, 10'd339}) begin
            $display("FAIL acl_hold: got %h/%0d want b/339", regi_packet_type, regi_payloadlen); n_err++;
        end
        n_vec++;
        boundary();
        tick();
        if ({tx_packet_st_p, sched_busy} !== 2'b00) begin
            $display("FAIL acl_skip2: got %b want 00", {tx_packet_st_p, sched_busy}); n_err++;
        end
        n_vec++;
        boundary();
        tick();
        if ({tx_packet_st_p, regi_packet_type} !== {1'b1, 4'h1}) begin
            $display("FAIL acl_third_bnd: got %b/%h want 1/1", tx_packet_st_p, regi_packet_type); n_err++;
        end
        n_vec++;
        pulse_tx(6);
        if (poll_done !== 1'b1) begin
            $display("FAIL acl_poll_done: got %b want 1", poll_done); n_err++;
        end
        n_vec++;
        poll_req = 1'b0;
    endtask

    task test_priority;
        sco_slot = 1'b1; acl_req = 1'b1; poll_req = 1'b1;
        acl_pk_type = 4'h3; acl_len = 10'd27; acl_slots = 3'd1;
        boundary();
        tick();
        if ({tx_packet_st_p, acl_gnt, regi_packet_type, regi_payloadlen} !== {2'b10, 4'h5, 10'd10}) begin
            $display("FAIL prio_sco: got %b%b/%h/%0d want 10/5/10",
                     tx_packet_st_p, acl_gnt, regi_packet_type, regi_payloadlen); n_err++;
        end
        n_vec++;
        sco_slot = 1'b0;
        pulse_tx(20);
        if ({acl_done, poll_done, sched_busy} !== 3'b000) begin
            $display("FAIL prio_sco_done: got %b want 000", {acl_done, poll_done, sched_busy}); n_err++;
        end
        n_vec++;
        boundary();
        tick();
        if ({tx_packet_st_p, acl_gnt, regi_packet_type} !== {2'b11, 4'h3}) begin
            $display("FAIL prio_acl_next: got %b%b/%h want 11/3", tx_packet_st_p, acl_gnt, regi_packet_type);
            n_err++;
        end
        n_vec++;
        pulse_tx(20);
        if (acl_done !== 1'b1) begin
            $display("FAIL prio_acl_done: got %b want 1", acl_done); n_err++;
        end
        n_vec++;
        acl_req = 1'b0; poll_req = 1'b0;
    endtask

    task test_same_cycle_req;
        boundary();
        poll_req = 1'b1;
        tick();
        if (tx_packet_st_p !== 1'b1) begin
            $display("FAIL same_cycle_req: got %b want 1", tx_packet_st_p); n_err++;
        end
        n_vec++;
        pulse_tx(6);
        poll_req = 1'b0;
    endtask

    task test_timeout;
        int n;
        bit got;
        n = 0; got = 1'b0;
        poll_req = 1'b1;
        boundary();
        tick();
        for (int i = 0; i < 5000 && !got; i++) begin
            tick();
            if (tx_err) got = 1'b1;
            else if (i > 0 && p_1us) n++;
        end
        if (!got || n !== 400) begin
            $display("FAIL timeout_ticks: got err=%0d after %0d us want err=1 after 400 us", got, n); n_err++;
        end
        n_vec++;
        if ({sched_busy, pk_encode, poll_done} !== 3'b000) begin
            $display("FAIL timeout_idle: got %b want 000", {sched_busy, pk_encode, poll_done}); n_err++;
        end
        n_vec++;
        boundary();
        tick();
        if (tx_packet_st_p !== 1'b1) begin
            $display("FAIL timeout_rearb: got %b want 1", tx_packet_st_p); n_err++;
        end
        n_vec++;
        pulse_tx(6);
        poll_req = 1'b0;
    endtask

    task test_conns_drop;
        acl_req = 1'b1; acl_pk_type = 4'h7; acl_len = 10'd50; acl_slots = 3'd5;
        boundary();
        tick();
        txbit_period = 1'b1;
        tick();
        tick();
        conns = 1'b0;
        tick();
        if ({pk_encode, tx_err, acl_done, sched_busy} !== 4'b0100) begin
            $display("FAIL conns_drop: got %b want 0100", {pk_encode, tx_err, acl_done, sched_busy}); n_err++;
        end
        n_vec++;
        conns = 1'b1; txbit_period = 1'b0;
        tick();
        if ({acl_done, tx_err} !== 2'b00) begin
            $display("FAIL conns_no_done: got %b want 00", {acl_done, tx_err}); n_err++;
        end
        n_vec++;
        boundary();
        tick();
        if (tx_packet_st_p !== 1'b1) begin
            $display("FAIL conns_skip_clr: got %b want 1", tx_packet_st_p); n_err++;
        end
        n_vec++;
        pulse_tx(6);
        acl_req = 1'b0;
        conns = 1'b0;
        tick();
        conns = 1'b1;
        tick();
    endtask

    task test_rst_mid_tx;
        acl_req = 1'b1; acl_pk_type = 4'h9; acl_len = 10'd100; acl_slots = 3'd1;
        boundary();
        tick();
        txbit_period = 1'b1;
        tick();
        #1 rst = 1'b1;
        #1;
        if ({pk_encode, sched_busy, tx_packet_st_p, regi_packet_type} !== 7'b0) begin
            $display("FAIL rst_async: got %b/%h want 000/0",
                     {pk_encode, sched_busy, tx_packet_st_p}, regi_packet_type); n_err++;
        end
        n_vec++;
        rst = 1'b0; txbit_period = 1'b0;
        tick();
        tick();
        boundary();
        tick();
        if ({tx_packet_st_p, acl_gnt, regi_packet_type} !== {2'b11, 4'h9}) begin
            $display("FAIL rst_restart: got %b%b/%h want 11/9", tx_packet_st_p, acl_gnt, regi_packet_type);
            n_err++;
        end
        n_vec++;
        pulse_tx(6);
        if (acl_done !== 1'b1) begin
            $display("FAIL rst_acl_done: got %b want 1", acl_done); n_err++;
        end
        n_vec++;
        acl_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; CLK = 28'd0; conns = 1'b0; sco_slot = 1'b0; acl_req = 1'b0; poll_req = 1'b0;
        txbit_period = 1'b0; acl_pk_type = 4'h0; acl_len = 10'd0; acl_slots = 3'd1;
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        conns = 1'b1;
        tick();
        test_poll();
        test_acl_multislot();
        test_priority();
        test_same_cycle_req();
        test_timeout();
        test_conns_drop();
        test_rst_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
